// File: rtl/rr_arb3_pkg.sv
// rr_arb3_pkg: shared encodings for the 3-way round-robin arbiter.
//   SEL_*   : mux select codes driven on rr_arb3.sel (2'b11 is never used)
//   IDX_*   : bit position of each requester in req/grant vectors
//   state_e : arbiter FSM states
//   onehot_to_sel : converts a one-hot grant into its mux select code
package rr_arb3_pkg;

    localparam int NUM_REQ = 3;

    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic [1:0] onehot_to_sel(input logic [NUM_REQ-1:0] oh);
        logic [1:0] s;
        s = SEL_A;
        if (oh[IDX_B]) s = SEL_B;
        if (oh[IDX_C]) s = SEL_C;
        return s;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational rotate-priority picker for three requesters.
//   req         : request vector (bit0 = A, bit1 = B, bit2 = C)
//   last        : select code of the most recent grantee; search starts after it
//   exclude     : requesters to ignore (the current grantee when forcing rotation)
//   pick_onehot : one-hot winner, 000 when nothing eligible
//   pick_any    : at least one eligible requester
module rr_pick3
    import rr_arb3_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic               pick_any
);

    logic [NUM_REQ-1:0] cand;

    assign cand     = req & ~exclude;
    assign pick_any = |cand;

    // The last grantee is scanned last, so it only wins when it is alone.
    always_comb begin
        pick_onehot = '0;
        case (last)
            SEL_A: begin
                if      (cand[IDX_B]) pick_onehot[IDX_B] = 1'b1;
                else if (cand[IDX_C]) pick_onehot[IDX_C] = 1'b1;
                else if (cand[IDX_A]) pick_onehot[IDX_A] = 1'b1;
            end
            SEL_B: begin
                if      (cand[IDX_C]) pick_onehot[IDX_C] = 1'b1;
                else if (cand[IDX_A]) pick_onehot[IDX_A] = 1'b1;
                else if (cand[IDX_B]) pick_onehot[IDX_B] = 1'b1;
            end
            default: begin
                if      (cand[IDX_A]) pick_onehot[IDX_A] = 1'b1;
                else if (cand[IDX_B]) pick_onehot[IDX_B] = 1'b1;
                else if (cand[IDX_C]) pick_onehot[IDX_C] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rr_arb3.sv
// rr_arb3: round-robin arbiter sharing one 3:1 operand mux between A, B, C.
//   clk, rst  : clock; synchronous active-high reset
//   req       : request vector (bit0 = A, bit1 = B, bit2 = C)
//   a, b, c   : operands, must be stable while the owner is granted
//   grant     : registered one-hot grant, 000 when idle
//   sel       : registered mux select (00 A, 01 B, 10 C), holds while idle
//   out_data  : operand chosen by sel, one cycle behind grant
//   out_valid : out_data carries a granted operand
// A grantee may keep the path for MAX_HOLD consecutive cycles while others
// wait; with nobody waiting the hold counter saturates and the grant stays.
module rr_arb3
    import rr_arb3_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  c,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         sel,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid
);

    localparam logic [3:0] MAX_H = 4'(MAX_HOLD);

    state_e             state, state_nxt;
    logic [3:0]         hold_cnt, hold_nxt;
    logic [1:0]         last, last_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [1:0]         sel_nxt;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic               cur_held;
    logic               take_pick;
    logic [DATA_W-1:0]  op_mux;

    // Excluding the current grantee only matters on forced rotation; when
    // the grantee has dropped req it is already absent from the candidates.
    rr_pick3 u_pick (
        .req         (req),
        .last        (last),
        .exclude     (grant),
        .pick_onehot (pick_onehot),
        .pick_any    (pick_any)
    );

    assign cur_held = |(req & grant);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        grant_nxt = grant;
        sel_nxt   = sel;
        take_pick = 1'b0;

        case (state)
            ST_IDLE: begin
                take_pick = pick_any;
            end
            ST_BUSY: begin
                if (cur_held) begin
                    if (hold_cnt < MAX_H) begin
                        hold_nxt = hold_cnt + 4'd1;
                    end else begin
                        // Quota used up: rotate only if someone else waits,
                        // otherwise keep the grant with the counter pinned.
                        take_pick = pick_any;
                    end
                end else if (pick_any) begin
                    take_pick = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase

        if (take_pick) begin
            state_nxt = ST_BUSY;
            grant_nxt = pick_onehot;
            sel_nxt   = onehot_to_sel(pick_onehot);
            last_nxt  = onehot_to_sel(pick_onehot);
            hold_nxt  = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            last     <= SEL_C;
            grant    <= '0;
            sel      <= SEL_A;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
        end
    end

    always_comb begin
        case (sel)
            SEL_A:   op_mux = a;
            SEL_B:   op_mux = b;
            SEL_C:   op_mux = c;
            default: op_mux = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= |grant;
            if (|grant) out_data <= op_mux;
        end
    end

endmodule
